// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause-22 frame constants, arbiter FSM states and the frame builder
// shared by the MDIO request arbiter.
package mdio_pkg;

    localparam logic [1:0] ST_C22  = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA      = 2'b10;
    localparam int         FRAME_W = 32;

    typedef enum logic [2:0] {IDLE, GRANT, LOAD, START, BUSY, DONE} state_t;

    function automatic logic [FRAME_W-1:0] mdio_frame(input logic wr, input logic [4:0] phy,
                                                      input logic [4:0] rad, input logic [15:0] data);
        return {ST_C22, wr ? OP_WR : OP_RD, phy, rad, TA, wr ? data : 16'h0};
    endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// mdio_rr_arbiter: one-hot round-robin pick of the first valid requester at or after ptr.
module mdio_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx
);

    logic [PW-1:0] j;

    // scan from the far end so the candidate nearest the pointer is written last
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NUM_REQ);
            if (valid[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/mdio_req_arbiter.sv
// mdio_req_arbiter: round-robin sharing of one Clause-22 MDIO master among NUM_REQ requesters.
// Define MDIO_POLL_EN to add a background link-status poller as a lowest-priority requester.
module mdio_req_arbiter
    import mdio_pkg::*;
#(
    parameter int         NUM_REQ     = 2,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [4:0] POLL_PHY    = 5'd1,
    parameter logic [4:0] POLL_REG    = 5'd1,
    parameter int         POLL_PERIOD = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [5*NUM_REQ-1:0]    req_phy,
    input  logic [5*NUM_REQ-1:0]    req_reg,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    MDIO_START,
    output logic [FRAME_W-1:0]      T_DATA,
    input  logic                    MDC,
    input  logic [15:0]             RD_DATA,
    input  logic                    DATA_RDY,
    output logic                    link_up
);

    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    // one width serves both the busy timeout and the poll interval
    localparam int CW = $clog2((TIMEOUT_CYC > POLL_PERIOD ? TIMEOUT_CYC : POLL_PERIOD) + 1);

    state_t               state, nxt;
    logic [NUM_REQ-1:0]   pick, own;
    logic [PW-1:0]        pick_idx, ptr;
    logic [4:0]           phy_a   [NUM_REQ];
    logic [4:0]           reg_a   [NUM_REQ];
    logic [15:0]          wdata_a [NUM_REQ];
    logic [CW-1:0]        tmo_cnt;
    logic [4:0]           mdc_cnt;
    logic [15:0]          rdata_q;
    logic [FRAME_W-1:0]   t_data_q;
    logic                 own_poll, wr_q, err_q, mdc_q, mdc_rise, poll_req, rd_done, wr_done, tmo, fin;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign phy_a[i]   = req_phy[5*i +: 5];
        assign reg_a[i]   = req_reg[5*i +: 5];
        assign wdata_a[i] = req_wdata[16*i +: 16];
    end

    mdio_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .gnt   (pick),
        .idx   (pick_idx)
    );

    assign mdc_rise = MDC & ~mdc_q;
    assign rd_done  = ~wr_q & DATA_RDY;
    assign wr_done  = wr_q & mdc_rise & (mdc_cnt == 5'd31);
    assign tmo      = tmo_cnt == CW'(TIMEOUT_CYC - 1);
    assign fin      = rd_done | wr_done | tmo;
    assign T_DATA   = t_data_q;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (|req_valid || poll_req) ? GRANT : IDLE;
            GRANT:   nxt = (|pick || poll_req) ? LOAD : IDLE;
            LOAD:    nxt = START;
            START:   nxt = BUSY;
            BUSY:    nxt = fin ? DONE : BUSY;
            default: nxt = IDLE;
        endcase
        req_gnt    = state == GRANT ? pick : '0;
        rsp_valid  = state == DONE ? own : '0;
        rsp_rdata  = (state == DONE && !own_poll) ? rdata_q : 16'h0;
        rsp_err    = state == DONE && !own_poll && err_q;
        busy       = state != IDLE;
        MDIO_START = state == START;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            own      <= '0;
            own_poll <= 1'b0;
            wr_q     <= 1'b0;
            t_data_q <= '0;
            tmo_cnt  <= '0;
            mdc_cnt  <= '0;
            mdc_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state   <= nxt;
            mdc_q   <= MDC;
            tmo_cnt <= state == BUSY ? tmo_cnt + 1'b1 : '0;
            mdc_cnt <= state != BUSY ? '0 : mdc_cnt + 5'(mdc_rise);
            // the last BUSY cycle leaves the matching response behind
            if (state == BUSY) begin
                rdata_q <= rd_done ? RD_DATA : wr_done ? 16'h0 : 16'hFFFF;
                err_q   <= ~(rd_done | wr_done);
            end
            if (state == GRANT && (|pick || poll_req)) begin
                own      <= pick;
                own_poll <= ~|pick;
                wr_q     <= |pick & req_write[pick_idx];
                ptr      <= ~|pick ? ptr : pick_idx == PW'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
                t_data_q <= |pick ? mdio_frame(req_write[pick_idx], phy_a[pick_idx], reg_a[pick_idx], wdata_a[pick_idx])
                                  : mdio_frame(1'b0, POLL_PHY, POLL_REG, 16'h0);
            end
        end
    end

`ifdef MDIO_POLL_EN
    logic          poll_pend, link_q;
    logic [CW-1:0] poll_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_pend <= 1'b0;
            poll_cnt  <= '0;
            link_q    <= 1'b0;
        end else begin
            poll_cnt  <= poll_cnt == CW'(POLL_PERIOD - 1) ? '0 : poll_cnt + 1'b1;
            poll_pend <= (poll_cnt == CW'(POLL_PERIOD - 1)) | (poll_pend & ~(state == GRANT && ~|pick));
            if (state == DONE && own_poll && !err_q)
                link_q <= rdata_q[2];
        end
    end

    assign poll_req = poll_pend;
    assign link_up  = link_q;
`else
    assign poll_req = 1'b0;
    assign link_up  = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// tb_mdio_req_arbiter: directed scoreboard bench for mdio_req_arbiter with a simple MDIO master model.
module tb_mdio_req_arbiter;

    localparam int N = 2;

    typedef struct {
        int          idx;
        int          kind;
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    logic            clk = 1'b0, reset = 1'b0;
    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [5*N-1:0]  req_phy = '0, req_reg = '0;
    logic [16*N-1:0] req_wdata = '0;
    logic [N-1:0]    req_gnt, rsp_valid;
    logic [15:0]     rsp_rdata;
    logic            rsp_err, busy, MDIO_START, link_up;
    logic [31:0]     T_DATA;
    logic            MDC = 1'b0, DATA_RDY = 1'b0;
    logic [15:0]     RD_DATA = 16'hDEAD;

    int          checks = 0, failures = 0;
    int          cyc = 0, rises = 0, r32 = 0, rdy_cyc = 0, start_cyc = 0, inflight = 0, rd_cnt = 0;
    int          rd_dly = 5;
    logic        mute = 1'b0, mdc_d = 1'b0;
    logic [15:0] rd_val = 16'h0;
    rsp_t        rsp_q[$];
    int          gnt_q[$];
    logic [31:0] frame_q[$];
    rsp_t        m_e;
    logic [31:0] m_exp;

    mdio_req_arbiter #(
        .NUM_REQ(N), .TIMEOUT_CYC(64), .POLL_PHY(5'd2), .POLL_REG(5'd1), .POLL_PERIOD(200)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_phy(req_phy),
        .req_reg(req_reg), .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .MDIO_START(MDIO_START),
        .T_DATA(T_DATA), .MDC(MDC), .RD_DATA(RD_DATA), .DATA_RDY(DATA_RDY), .link_up(link_up)
    );

    always #5 clk = ~clk;

    // MDIO master model: MDC at clk/2, DATA_RDY pulse rd_dly cycles after every start unless muted
    always @(posedge clk) begin
        #1;
        MDC      = ~MDC;
        DATA_RDY = 1'b0;
        RD_DATA  = 16'hDEAD;
        if (MDIO_START && !mute) rd_cnt = rd_dly;
        else if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                DATA_RDY = 1'b1;
                RD_DATA  = rd_val;
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame(logic wr, logic [4:0] p, logic [4:0] r, logic [15:0] d);
        return {2'b01, wr ? 2'b01 : 2'b10, p, r, 2'b10, wr ? d : 16'h0};
    endfunction

    // monitor: pops the scoreboards as grants, starts and responses appear
    always @(negedge clk) begin
        cyc++;
        if (!busy) inflight = 0;
        if (MDIO_START) begin
            check("one_start_in_flight", inflight, 0);
            inflight  = 1;
            rises     = 0;
            start_cyc = cyc;
            m_exp     = frame_q.size() ? frame_q.pop_front() : 32'hX;
            check("t_data", T_DATA, m_exp);
        end else if (MDC && !mdc_d) begin
            rises++;
            if (rises == 32) r32 = cyc;
        end
        mdc_d = MDC;
        if (DATA_RDY) rdy_cyc = cyc;
        if (|req_gnt) begin
            m_exp = gnt_q.size() ? 32'(1 << gnt_q.pop_front()) : 32'h0;
            check("req_gnt", req_gnt, m_exp);
        end
        if (|rsp_valid) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else begin
                m_e = rsp_q.pop_front();
                check("rsp_valid", rsp_valid, 32'(1 << m_e.idx));
                check("rsp_rdata", rsp_rdata, m_e.rdata);
                check("rsp_err", rsp_err, m_e.err);
                if (m_e.kind == 0) check("wr_latency", cyc, r32 + 1);
                else if (m_e.kind == 1) check("rd_latency", cyc, rdy_cyc + 1);
                else check("tmo_latency", cyc, start_cyc + 65);
            end
        end
    end

    task automatic issue(int i, logic wr, logic [4:0] phy, logic [4:0] rg, logic [15:0] wd, logic [31:0] fr);
        rsp_t e;
        req_write[i]         = wr;
        req_phy[5*i +: 5]    = phy;
        req_reg[5*i +: 5]    = rg;
        req_wdata[16*i +: 16] = wd;
        req_valid[i]         = 1'b1;
        gnt_q.push_back(i);
        frame_q.push_back(fr);
        e.idx   = i;
        e.kind  = wr ? 0 : mute ? 2 : 1;
        e.err   = !wr && mute;
        e.rdata = wr ? 16'h0 : mute ? 16'hFFFF : rd_val;
        rsp_q.push_back(e);
    endtask

    // hold each request until its grant has been seen, then drop it
    task automatic serve();
        logic [N-1:0] g;
        int n = 0;
        while (req_valid != '0 && n < 1000) begin
            @(negedge clk);
            g = req_gnt;
            @(posedge clk);
            #1 req_valid = req_valid & ~g;
            n++;
        end
        check("grant_bound", n < 1000, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", n < 2000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        check("rst_ctl", {req_gnt, rsp_valid, rsp_err, busy, MDIO_START, link_up}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_tdata", T_DATA, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
`ifdef MDIO_POLL_EN
        check("link_up_init", link_up, 0);
        rd_val = 16'h0004;
        rd_dly = 60;
        repeat (150) @(posedge clk);
        #1 issue(0, 1'b0, 5'd3, 5'd2, 16'h0, frame(1'b0, 5'd3, 5'd2, 16'h0));
        @(posedge clk);
        #1 issue(1, 1'b0, 5'd4, 5'd5, 16'h0, frame(1'b0, 5'd4, 5'd5, 16'h0));
        frame_q.push_back(frame(1'b0, 5'd2, 5'd1, 16'h0));
        serve();
        drain();
        n = 0;
        while (!link_up && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("link_up_poll", link_up, 1);
        check("poll_started", frame_q.size(), 0);
`else
        // single write: grant latency, frame, start pulse, 32-edge completion
        issue(0, 1'b1, 5'd3, 5'h1A, 16'hF5B5, 32'h51EAF5B5);
        @(negedge clk); check("gnt_early", req_gnt, 0);
        @(negedge clk); check("gnt0_latency", req_gnt, 2'b01); check("busy_grant", busy, 1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk); check("tdata_load", T_DATA, 32'h51EAF5B5); check("start_load", MDIO_START, 0);
        @(negedge clk); check("start_pulse", MDIO_START, 1);
        // a request withdrawn while busy must never be granted
        @(posedge clk); #1 req_valid[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk); check("tdata_hold", T_DATA, 32'h51EAF5B5);
        drain();
        // read from requester 1
        rd_val = 16'h796D;
        @(posedge clk); #1 issue(1, 1'b0, 5'd1, 5'd1, 16'h0, 32'h60860000);
        serve();
        drain();
        // simultaneous requests with pointer at 0
        rd_val = 16'hA55A;
        @(posedge clk); #1 issue(0, 1'b1, 5'd5, 5'd2, 16'h1234, frame(1'b1, 5'd5, 5'd2, 16'h1234));
        issue(1, 1'b0, 5'd7, 5'd3, 16'h0, frame(1'b0, 5'd7, 5'd3, 16'h0));
        serve();
        drain();
        // read that never completes
        mute = 1'b1;
        @(posedge clk); #1 issue(0, 1'b0, 5'd1, 5'd30, 16'h0, frame(1'b0, 5'd1, 5'd30, 16'h0));
        serve();
        drain();
        mute = 1'b0;
        // simultaneous requests with pointer at 1
        rd_val = 16'h0F0F;
        @(posedge clk); #1 issue(1, 1'b0, 5'd2, 5'd4, 16'h0, frame(1'b0, 5'd2, 5'd4, 16'h0));
        issue(0, 1'b1, 5'd6, 5'd7, 16'hBEEF, frame(1'b1, 5'd6, 5'd7, 16'hBEEF));
        serve();
        drain();
        // reset in the middle of a write
        @(posedge clk); #1 issue(0, 1'b1, 5'd9, 5'd4, 16'h0BAD, frame(1'b1, 5'd9, 5'd4, 16'h0BAD));
        serve();
        n = 0;
        while (!MDIO_START && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", MDIO_START, 1);
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        rsp_q.delete();
        #1;
        check("rst_mid_ctl", {req_gnt, rsp_valid, rsp_err, busy, MDIO_START, link_up}, 0);
        check("rst_mid_rdata", rsp_rdata, 0);
        check("rst_mid_tdata", T_DATA, 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        rd_val = 16'h1357;
        issue(1, 1'b0, 5'd8, 5'd9, 16'h0, frame(1'b0, 5'd8, 5'd9, 16'h0));
        serve();
        drain();
        check("link_up_off", link_up, 0);
`endif
        check("scoreboard_empty", rsp_q.size() + gnt_q.size() + frame_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
